// File: rtl/regfile_ctrl_pkg.sv
// Shared types and sizing for the register-file access controller.
// Holds the controller state encoding, the register-file geometry and an address range helper.
package regfile_ctrl_pkg;

    localparam int RF_ADDR_W        = 5;
    localparam int RF_DATA_W        = 32;
    localparam int DEFAULT_NUM_REGS = 32;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_EXEC = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // One extra bit so NUM_REGS=32 compares correctly against a 5-bit address.
    function automatic logic addr_in_range(input logic [RF_ADDR_W-1:0] addr, input int num_regs);
        return ({1'b0, addr} < (RF_ADDR_W+1)'(num_regs));
    endfunction

endpackage

// File: rtl/regfile_access_ctrl.sv
// Sequencing controller for the 32 x 32 register file: initial sweep after reset,
// then one read or write request at a time over valid/ready request/response channels.
module regfile_access_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int                   NUM_REGS      = DEFAULT_NUM_REGS,
    parameter logic [RF_DATA_W-1:0] INIT_VALUE    = '0,
    parameter bit                   INIT_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [RF_ADDR_W-1:0] req_addr,
    input  logic [RF_DATA_W-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_write,
    output logic                 rsp_err,
    output logic [RF_DATA_W-1:0] rsp_rdata,
    output logic                 init_done,
    output logic                 rf_reg_write,
    output logic [RF_ADDR_W-1:0] rf_wr_addr,
    output logic [RF_DATA_W-1:0] rf_write_data,
    output logic [RF_ADDR_W-1:0] rf_rd_addr,
    input  logic [RF_DATA_W-1:0] rf_rd_data
);

    localparam logic [RF_ADDR_W-1:0] LAST_IDX = RF_ADDR_W'(NUM_REGS - 1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [RF_ADDR_W-1:0]   r_idx;
    logic                   r_sweep_end;
    logic                   r_wr;
    logic                   r_err;
    logic [RF_DATA_W-1:0]   r_wdata;
    logic                   w_accept;
    logic                   w_in_range;

    assign w_accept   = (r_state == ST_IDLE) && req_valid && req_ready;
    assign w_in_range = addr_in_range(req_addr, NUM_REGS);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= INIT_ON_RESET ? ST_INIT : ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_INIT: if (r_sweep_end) w_next_state = ST_IDLE;
            ST_IDLE: if (w_accept)    w_next_state = ST_EXEC;
            ST_EXEC:                  w_next_state = ST_RESP;
            ST_RESP: if (rsp_ready)   w_next_state = ST_IDLE;
            default:                  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_err       <= 1'b0;
            rsp_rdata     <= '0;
            init_done     <= 1'b0;
            rf_reg_write  <= 1'b0;
            rf_wr_addr    <= '0;
            rf_write_data <= '0;
            rf_rd_addr    <= '0;
            r_idx         <= '0;
            r_sweep_end   <= 1'b0;
            r_wr          <= 1'b0;
            r_err         <= 1'b0;
            r_wdata       <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    // The last index holds instead of incrementing, so a full 32-entry sweep never wraps.
                    if (r_sweep_end) begin
                        rf_reg_write <= 1'b0;
                        req_ready    <= 1'b1;
                        init_done    <= 1'b1;
                        r_sweep_end  <= 1'b0;
                    end else begin
                        rf_reg_write  <= 1'b1;
                        rf_wr_addr    <= r_idx;
                        rf_write_data <= INIT_VALUE;
                        if (r_idx == LAST_IDX) begin
                            r_sweep_end <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ST_IDLE: begin
                    init_done <= 1'b1;
                    if (w_accept) begin
                        req_ready <= 1'b0;
                        r_wr      <= req_write;
                        r_err     <= ~w_in_range;
                        r_wdata   <= req_wdata;
                        if (req_write) begin
                            rf_reg_write  <= w_in_range;
                            rf_wr_addr    <= req_addr;
                            rf_write_data <= req_wdata;
                        end else begin
                            rf_rd_addr <= req_addr;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    // The register file commits the write on the falling edge inside this cycle.
                    rf_reg_write <= 1'b0;
                    rsp_valid    <= 1'b1;
                    rsp_write    <= r_wr;
                    rsp_err      <= r_err;
                    if (r_wr) begin
                        rsp_rdata <= r_wdata;
                    end else if (r_err) begin
                        rsp_rdata <= '0;
                    end else begin
                        rsp_rdata <= rf_rd_data;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Scoreboard bench for regfile_access_ctrl: a 32-register instance and a 16-register instance,
// each beside a behavioural register file (falling-edge write, combinational read).
module tb_regfile_access_ctrl;

    typedef struct packed {
        logic        wr;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, req_valid_a, req_ready_a, req_write_a, rsp_valid_a, rsp_ready_a;
    logic        rsp_write_a, rsp_err_a, init_done_a, rf_we_a;
    logic [4:0]  req_addr_a, rf_wa_a, rf_ra_a;
    logic [31:0] req_wdata_a, rsp_rdata_a, rf_wd_a, rf_rd_a;
    logic [31:0] rf_mem_a [32];

    logic        rst_b, req_valid_b, req_ready_b, req_write_b, rsp_valid_b, rsp_ready_b;
    logic        rsp_write_b, rsp_err_b, init_done_b, rf_we_b;
    logic [4:0]  req_addr_b, rf_wa_b, rf_ra_b;
    logic [31:0] req_wdata_b, rsp_rdata_b, rf_wd_b, rf_rd_b;
    logic [31:0] rf_mem_b [32];

    rsp_t q_a[$];
    rsp_t q_b[$];
    int   n_chk = 0;
    int   n_err = 0;

    regfile_access_ctrl #(.NUM_REGS(32), .INIT_VALUE(32'hA5A5_A5A5), .INIT_ON_RESET(1'b1)) u_dut_a (
        .clk(clk), .reset(rst_a),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_write(req_write_a),
        .req_addr(req_addr_a), .req_wdata(req_wdata_a),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a), .rsp_write(rsp_write_a),
        .rsp_err(rsp_err_a), .rsp_rdata(rsp_rdata_a), .init_done(init_done_a),
        .rf_reg_write(rf_we_a), .rf_wr_addr(rf_wa_a), .rf_write_data(rf_wd_a),
        .rf_rd_addr(rf_ra_a), .rf_rd_data(rf_rd_a)
    );

    regfile_access_ctrl #(.NUM_REGS(16), .INIT_VALUE(32'h1111_1111), .INIT_ON_RESET(1'b1)) u_dut_b (
        .clk(clk), .reset(rst_b),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write_b),
        .req_addr(req_addr_b), .req_wdata(req_wdata_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_write(rsp_write_b),
        .rsp_err(rsp_err_b), .rsp_rdata(rsp_rdata_b), .init_done(init_done_b),
        .rf_reg_write(rf_we_b), .rf_wr_addr(rf_wa_b), .rf_write_data(rf_wd_b),
        .rf_rd_addr(rf_ra_b), .rf_rd_data(rf_rd_b)
    );

    always @(negedge clk) if (rf_we_a) rf_mem_a[rf_wa_a] <= rf_wd_a;
    always @(negedge clk) if (rf_we_b) rf_mem_b[rf_wa_b] <= rf_wd_b;
    assign rf_rd_a = rf_mem_a[rf_ra_a];
    assign rf_rd_b = rf_mem_b[rf_ra_b];

    task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitors: one comparison per completed response handshake.
    always @(negedge clk) begin
        rsp_t e;
        if (rsp_valid_a && rsp_ready_a) begin
            if (q_a.size() == 0) begin
                chk("rsp_a_unexpected", 34'(q_a.size()), 34'(1));
            end else begin
                e = q_a.pop_front();
                chk("rsp_a", {rsp_write_a, rsp_err_a, rsp_rdata_a}, e);
            end
        end
    end

    always @(negedge clk) begin
        rsp_t e;
        if (rsp_valid_b && rsp_ready_b) begin
            if (q_b.size() == 0) begin
                chk("rsp_b_unexpected", 34'(q_b.size()), 34'(1));
            end else begin
                e = q_b.pop_front();
                chk("rsp_b", {rsp_write_b, rsp_err_b, rsp_rdata_b}, e);
            end
        end
    end

    task automatic wait_ready(input bit b);
        int n = 0;
        while (!(b ? req_ready_b : req_ready_a) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk(b ? "ready_wait_b" : "ready_wait_a", 34'(b ? req_ready_b : req_ready_a), 34'(1));
    endtask

    task automatic issue(input bit b, input logic wr, input logic [4:0] addr, input logic [31:0] wd);
        if (b) begin
            req_valid_b = 1'b1; req_write_b = wr; req_addr_b = addr; req_wdata_b = wd;
        end else begin
            req_valid_a = 1'b1; req_write_a = wr; req_addr_a = addr; req_wdata_a = wd;
        end
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
    endtask

    task automatic do_txn(input bit b, input logic wr, input logic [4:0] addr, input logic [31:0] wd,
                          input logic exp_err, input logic [31:0] exp_data);
        rsp_t e;
        wait_ready(b);
        e = '{wr: wr, err: exp_err, data: exp_data};
        if (b) q_b.push_back(e); else q_a.push_back(e);
        issue(b, wr, addr, wd);
        wait_ready(b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst_a = 1'b1; rst_b = 1'b1;
        req_valid_a = 1'b0; req_write_a = 1'b0; req_addr_a = '0; req_wdata_a = '0; rsp_ready_a = 1'b1;
        req_valid_b = 1'b0; req_write_b = 1'b0; req_addr_b = '0; req_wdata_b = '0; rsp_ready_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", 34'({req_ready_a, rsp_valid_a, init_done_a, rf_we_a}), 34'(0));
        chk("reset_data", 34'(rsp_rdata_a), 34'(0));
        chk("reset_addr", 34'({rf_wa_a, rf_ra_a}), 34'(0));

        // Request held during the sweep must be taken only once IDLE is reached.
        q_a.push_back('{wr: 1'b0, err: 1'b0, data: 32'hA5A5_A5A5});
        req_valid_a = 1'b1; req_write_a = 1'b0; req_addr_a = 5'd17;
        rst_a = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            chk("sweep_we", 34'(rf_we_a), 34'(1));
            chk("sweep_addr", 34'(rf_wa_a), 34'(i));
            chk("sweep_ready", 34'({req_ready_a, init_done_a}), 34'(0));
        end
        chk("sweep_data", 34'(rf_wd_a), 34'(32'hA5A5_A5A5));
        @(posedge clk); #1;
        chk("sweep_end", 34'({rf_we_a, req_ready_a, init_done_a}), 34'(3'b011));
        @(posedge clk); #1;
        chk("held_req_accept", 34'(req_ready_a), 34'(0));
        req_valid_a = 1'b0;
        wait_ready(1'b0);

        do_txn(1'b0, 1'b0, 5'd0,  32'h0, 1'b0, 32'hA5A5_A5A5);
        do_txn(1'b0, 1'b0, 5'd31, 32'h0, 1'b0, 32'hA5A5_A5A5);
        do_txn(1'b0, 1'b1, 5'd5,  32'h0000_0005, 1'b0, 32'h0000_0005);

        // Read latency: response appears exactly one cycle after the accept edge.
        wait_ready(1'b0);
        q_a.push_back('{wr: 1'b0, err: 1'b0, data: 32'h0000_0005});
        issue(1'b0, 1'b0, 5'd5, 32'h0);
        chk("lat_exec_valid", 34'(rsp_valid_a), 34'(0));
        @(posedge clk); #1;
        chk("lat_valid", 34'(rsp_valid_a), 34'(1));
        chk("lat_data", 34'(rsp_rdata_a), 34'(5));
        wait_ready(1'b0);

        do_txn(1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF);
        do_txn(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'hDEAD_BEEF);
        do_txn(1'b0, 1'b0, 5'd6, 32'h0, 1'b0, 32'hA5A5_A5A5);

        // Back-pressure on the response channel.
        rsp_ready_a = 1'b0;
        wait_ready(1'b0);
        q_a.push_back('{wr: 1'b0, err: 1'b0, data: 32'h0000_0005});
        issue(1'b0, 1'b0, 5'd5, 32'h0);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", 34'(rsp_valid_a), 34'(1));
            chk("bp_data", 34'(rsp_rdata_a), 34'(5));
            chk("bp_ready", 34'(req_ready_a), 34'(0));
            @(posedge clk); #1;
        end
        rsp_ready_a = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", 34'({req_ready_a, rsp_valid_a}), 34'(2'b10));

        // Reset while a response is pending: response discarded, sweep restarts.
        rsp_ready_a = 1'b0;
        wait_ready(1'b0);
        issue(1'b0, 1'b0, 5'd5, 32'h0);
        @(posedge clk); #1;
        chk("mid_valid", 34'(rsp_valid_a), 34'(1));
        rst_a = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_ctrl", 34'({rsp_valid_a, req_ready_a, init_done_a, rf_we_a}), 34'(0));
        chk("mid_rst_data", 34'(rsp_rdata_a), 34'(0));
        rst_a = 1'b0;
        rsp_ready_a = 1'b1;
        @(posedge clk); #1;
        chk("restart_we_addr", 34'({rf_we_a, rf_wa_a}), 34'({1'b1, 5'd0}));
        wait_ready(1'b0);
        do_txn(1'b0, 1'b0, 5'd5, 32'h0, 1'b0, 32'hA5A5_A5A5);

        // 16-register instance: sweep length and out-of-range handling.
        rst_b = 1'b0;
        cnt = 0;
        for (int i = 0; i < 60 && !init_done_b; i++) begin
            @(posedge clk); #1;
            if (rf_we_b) cnt++;
        end
        chk("b_sweep_len", 34'(cnt), 34'(16));
        chk("b_done", 34'({init_done_b, req_ready_b}), 34'(2'b11));

        wait_ready(1'b1);
        q_b.push_back('{wr: 1'b1, err: 1'b1, data: 32'h0000_00FF});
        issue(1'b1, 1'b1, 5'd20, 32'h0000_00FF);
        chk("oor_no_we_exec", 34'(rf_we_b), 34'(0));
        @(posedge clk); #1;
        chk("oor_no_we_resp", 34'(rf_we_b), 34'(0));
        wait_ready(1'b1);
        do_txn(1'b1, 1'b0, 5'd20, 32'h0, 1'b1, 32'h0);
        do_txn(1'b1, 1'b0, 5'd16, 32'h0, 1'b1, 32'h0);
        do_txn(1'b1, 1'b0, 5'd4,  32'h0, 1'b0, 32'h1111_1111);
        do_txn(1'b1, 1'b1, 5'd15, 32'h0000_0055, 1'b0, 32'h0000_0055);
        do_txn(1'b1, 1'b0, 5'd15, 32'h0, 1'b0, 32'h0000_0055);

        for (int i = 0; i < 20 && (q_a.size() != 0 || q_b.size() != 0); i++) begin
            @(posedge clk); #1;
        end
        chk("q_a_drained", 34'(q_a.size()), 34'(0));
        chk("q_b_drained", 34'(q_b.size()), 34'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_access_ctrl.md
# regfile_access_ctrl

Sequencing controller that drives the write port and one read port of the 32 x 32-bit register file.
- On reset it sweeps INIT_VALUE into every register.
- It then serves single read/write requests over a valid/ready request channel and returns each result over a valid/ready response channel.
- It sits between a test/host master and the register file. The register file captures writes on the falling clock edge and reads combinationally.

## Interface
- NUM_REGS, 32: number of registers, 1..32. Addresses >= NUM_REGS are out of range.
- INIT_VALUE, 32'h0: value written to every register during the init sweep.
- INIT_ON_RESET, 1: 1 = run the sweep after reset; 0 = go straight to IDLE.
- clk  in  1  rising-edge clock for all controller state.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  5  register address.
- req_wdata  in  32  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  master accepts the response.
- rsp_write  out  1  echo of req_write.
- rsp_err  out  1  address was out of range.
- rsp_rdata  out  32  read data; for writes, the written data.
- init_done  out  1  sweep complete, sticky until reset.
- rf_reg_write  out  1  register-file write enable.
- rf_wr_addr  out  5  register-file write address.
- rf_write_data  out  32  register-file write data.
- rf_rd_addr  out  5  register-file read select.
- rf_rd_data  in  32  register-file read data (combinational).

## Operation
- All outputs are registered. Reset value of every output is 0.
- States: INIT, IDLE, EXEC, RESP.
- Reset enters INIT when INIT_ON_RESET=1, otherwise IDLE.
- INIT:
  - 5-bit index idx runs 0..NUM_REGS-1, one per cycle.
  - Drives rf_reg_write=1, rf_wr_addr=idx, rf_write_data=INIT_VALUE.
  - After idx=NUM_REGS-1 goes to IDLE.
  - req_valid is ignored; req_ready=0.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch the request and go to EXEC.
  - Write: rf_reg_write=1, rf_wr_addr=req_addr, rf_write_data=req_wdata.
  - Read: rf_rd_addr=req_addr.
- EXEC (exactly one cycle):
  - rf_reg_write returns to 0.
  - Read: rsp_rdata <= rf_rd_data.
  - Write: rsp_rdata <= latched wdata.
  - rsp_write and rsp_err are set; rsp_valid=1; go to RESP.
- RESP:
  - Hold rsp_valid and all response fields stable until rsp_ready.
  - On the handshake: rsp_valid=0, req_ready=1, go to IDLE.
- Out-of-range address: write is suppressed (rf_reg_write stays 0), read returns 0, rsp_err=1.
- Register 0 gets no special handling; it is writable.
- init_done=1 from the edge that enters IDLE until reset. When INIT_ON_RESET=0 it is 1 from the first edge with reset low.

## Timing
- Sweep:
  - First rising edge with reset low: rf_reg_write=1, rf_wr_addr=0.
  - rf_reg_write stays high for exactly NUM_REGS cycles.
  - The edge ending the sweep sets rf_reg_write=0, req_ready=1 and init_done=1 together.
- Transaction:
  - Accept at edge A → EXEC cycle.
  - Edge A+1: rsp_valid=1.
  - Handshake edge ≥ A+2: req_ready=1.
  - Minimum 3 cycles per transaction; no pipelining, one outstanding request.
- Writes complete on the falling edge inside EXEC. Any later read sees the new value.
- Read data is sampled at the rising edge that ends EXEC; rf_rd_addr is stable for the whole cycle.
- rsp_ready held high in RESP completes the response in that same cycle.
- Reset mid-transaction or mid-sweep:
  - All outputs go to 0 at the reset edge.
  - The pending response is discarded; the sweep restarts from idx 0.
- With NUM_REGS=32, idx stops at 31 and never wraps into a second sweep.

## Structure
- Shared package regfile_ctrl_pkg holds:
  - the state enum (INIT, IDLE, EXEC, RESP);
  - RF_ADDR_W=5 and RF_DATA_W=32;
  - the default NUM_REGS.
- Single module; no sub-module. The sweep counter and FSM are small enough to stay inline.
- A test wrapper instantiates regfile_access_ctrl next to the register file. rf_rd_addr drives its rs select; the rt port is unused.

## Test plan
- Sweep: INIT_VALUE=32'hA5A5A5A5, release reset → rf_reg_write high for 32 cycles with addresses 0..31, then init_done=1, req_ready=1; reads of r0, r17 and r31 return A5A5A5A5.
- Write then read: write r5=32'h0000_0005 → rsp_write=1, rsp_rdata=5, rsp_err=0; read r5 → rsp_rdata=5 exactly 1 cycle after the accept edge.
- Back-pressure: read r5 with rsp_ready=0 for 4 cycles → rsp_valid and rsp_rdata=5 held stable, req_ready=0 throughout; rsp_ready=1 → next cycle req_ready=1.
- Out of range: NUM_REGS=16, write r20=32'hFF → no rf_reg_write pulse, rsp_err=1; read r20 → rsp_rdata=0, rsp_err=1.
- Reset mid-op: assert reset during RESP of read r5 → rsp_valid=0 next edge; sweep restarts at address 0 and r5 reads INIT_VALUE afterwards.
- Ignored request: req_valid=1 during INIT → not accepted until init_done=1, then accepted on the first IDLE edge.
